tf_addr_seq_gen: RTL and testbench

//  Self-sequencing twiddle-factor ROM address generator for the mixed-radix NTT/INTT core.
//  On start it walks every stage and every twiddle index, emitting LANES addresses per beat

---
 rtl/tf_pkg.sv | 32 +++
 rtl/tf_addr_seq_gen_if.sv | 27 ++
 rtl/tf_stage_table.sv | 27 ++
 rtl/tf_addr_seq_gen.sv | 179 +++++++++++++++++
 tb/tb_tf_addr_seq_gen.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tf_pkg.sv
// Shared types, constants and table math for the twiddle-factor address generator.
package tf_pkg;

  localparam logic TF_NTT  = 1'b0;
  localparam logic TF_INTT = 1'b1;

  typedef enum logic {IDLE, RUN} tf_state_e;

  // Twiddle count of stage s: grows by 2^radix_log per stage.
  function automatic int unsigned stage_cnt(input int unsigned s,
                                            input int unsigned first_cnt,
                                            input int unsigned radix_log);
    return first_cnt << (radix_log * s);
  endfunction

  // Table offset of stage s: sum of the counts of all earlier stages.
  function automatic int unsigned stage_base(input int unsigned s,
                                             input int unsigned first_cnt,
                                             input int unsigned radix_log);
    int unsigned acc;
    acc = 0;
    for (int unsigned j = 0; j < s; j++) acc += stage_cnt(j, first_cnt, radix_log);
    return acc;
  endfunction

  function automatic int unsigned tf_total(input int unsigned num_stages,
                                           input int unsigned first_cnt,
                                           input int unsigned radix_log);
    return stage_base(num_stages, first_cnt, radix_log);
  endfunction

endpackage

// File: rtl/tf_addr_seq_gen_if.sv
// Control/beat bus between the NTT controller, the address generator and the twiddle ROM.
interface tf_addr_seq_gen_if #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned STG_W  = 2
);
  logic                      start;
  logic                      mode;
  logic                      out_ready;
  logic                      out_valid;
  logic [LANES*ADDR_W-1:0]   tf_addr;
  logic [LANES-1:0]          lane_en;
  logic [STG_W-1:0]          stage;
  logic                      last;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, mode, out_ready,
    output out_valid, tf_addr, lane_en, stage, last, busy, done
  );

  modport slave (
    output start, mode, out_ready,
    input  out_valid, tf_addr, lane_en, stage, last, busy, done
  );
endinterface

// File: rtl/tf_stage_table.sv
// Combinational stage index -> {base, count} lookup for the twiddle table.
module tf_stage_table
  import tf_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned FIRST_CNT  = 2,
  parameter int unsigned RADIX_LOG  = 2,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STG_W      = 2
) (
  input  logic [STG_W-1:0]  stg,
  output logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] cnt
);

  always_comb begin
    base = '0;
    cnt  = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      if (stg == STG_W'(s)) begin
        base = ADDR_W'(stage_base(s, FIRST_CNT, RADIX_LOG));
        cnt  = ADDR_W'(stage_cnt(s, FIRST_CNT, RADIX_LOG));
      end
    end
  end

endmodule

// File: rtl/tf_addr_seq_gen.sv
// Twiddle ROM address sequencer: walks every stage/index of the forward or inverse
// table after start and streams LANES addresses per beat over valid/ready.
module tf_addr_seq_gen
  import tf_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned FIRST_CNT  = 2,
  parameter int unsigned RADIX_LOG  = 2,
  parameter int unsigned LANES      = 1,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STG_W      = 2
) (
  input logic                clk,
  input logic                rst,
  tf_addr_seq_gen_if.master  bus
);

  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned AW    = LANES * ADDR_W;
  localparam int unsigned TOTAL = tf_total(NUM_STAGES, FIRST_CNT, RADIX_LOG);

  if (2 * TOTAL > (1 << ADDR_W)) begin : g_bad_params
    $error("tf_addr_seq_gen: ADDR_W too narrow for forward+inverse tables");
  end

  tf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [STG_W-1:0]  stg_q, stg_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [AW-1:0]     tf_addr_q, tf_addr_d;
  logic [LANES-1:0]  lane_en_q, lane_en_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              load;
  logic              clr;
  logic [CW-1:0]     k_step;
  logic [ADDR_W-1:0] nxt_base;
  logic [ADDR_W-1:0] nxt_cnt;
  logic [ADDR_W-1:0] addr_off;
  logic [STG_W-1:0]  final_stg;

  tf_stage_table #(
    .NUM_STAGES (NUM_STAGES),
    .FIRST_CNT  (FIRST_CNT),
    .RADIX_LOG  (RADIX_LOG),
    .ADDR_W     (ADDR_W),
    .STG_W      (STG_W)
  ) u_tbl (
    .stg  (stg_d),
    .base (nxt_base),
    .cnt  (nxt_cnt)
  );

  // Sequencing: picks the next (stage, k) and whether to load a new beat or clear.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    stg_d       = stg_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load        = 1'b0;
    clr         = 1'b0;
    k_step      = {1'b0, k_q} + CW'(LANES);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d      = bus.mode;
          k_d         = '0;
          stg_d       = (bus.mode == TF_INTT) ? STG_W'(NUM_STAGES - 1) : '0;
          state_d     = RUN;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          load        = 1'b1;
        end
      end
      RUN: begin
        if (out_valid_q && bus.out_ready) begin
          if (last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            k_d         = '0;
            stg_d       = '0;
            clr         = 1'b1;
          end else begin
            load = 1'b1;
            if (k_step >= {1'b0, cnt_q}) begin
              k_d   = '0;
              stg_d = (mode_q == TF_INTT) ? stg_q - STG_W'(1) : stg_q + STG_W'(1);
            end else begin
              k_d = k_step[ADDR_W-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat generation for the (stage, k) chosen above; disabled lanes drive address 0.
  always_comb begin
    tf_addr_d = tf_addr_q;
    lane_en_d = lane_en_q;
    stage_d   = stage_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_off  = (mode_d == TF_INTT) ? ADDR_W'(TOTAL) : '0;
    final_stg = (mode_d == TF_INTT) ? '0 : STG_W'(NUM_STAGES - 1);

    if (load) begin
      cnt_d   = nxt_cnt;
      stage_d = stg_d;
      last_d  = (stg_d == final_stg) && (({1'b0, k_d} + CW'(LANES)) >= {1'b0, nxt_cnt});
      for (int i = 0; i < int'(LANES); i++) begin
        if (({1'b0, k_d} + CW'(i)) < {1'b0, nxt_cnt}) begin
          lane_en_d[i]                  = 1'b1;
          tf_addr_d[i*ADDR_W +: ADDR_W] = addr_off + nxt_base + k_d + ADDR_W'(i);
        end else begin
          lane_en_d[i]                  = 1'b0;
          tf_addr_d[i*ADDR_W +: ADDR_W] = '0;
        end
      end
    end else if (clr) begin
      tf_addr_d = '0;
      lane_en_d = '0;
      stage_d   = '0;
      last_d    = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      stg_q       <= '0;
      mode_q      <= TF_NTT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      tf_addr_q   <= '0;
      lane_en_q   <= '0;
      stage_q     <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      stg_q       <= stg_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      tf_addr_q   <= tf_addr_d;
      lane_en_q   <= lane_en_d;
      stage_q     <= stage_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.tf_addr   = tf_addr_q;
  assign bus.lane_en   = lane_en_q;
  assign bus.stage     = stage_q;
  assign bus.last      = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_tf_addr_seq_gen.sv
// Bench for tf_addr_seq_gen: a LANES=1 and a LANES=4 instance checked against a queue-based table model.
module tb_tf_addr_seq_gen;

  typedef struct packed {
    logic [35:0] addr;
    logic [3:0]  en;
    logic [1:0]  stage;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic start_r = 1'b0;
  logic mode_r = 1'b0;
  logic ready_r = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  tf_addr_seq_gen_if #(.LANES(1), .ADDR_W(9), .STG_W(2)) if1 ();
  tf_addr_seq_gen_if #(.LANES(4), .ADDR_W(9), .STG_W(2)) if4 ();

  assign if1.start     = !sel && start_r;
  assign if1.mode      = mode_r;
  assign if1.out_ready = ready_r;
  assign if4.start     = sel && start_r;
  assign if4.mode      = mode_r;
  assign if4.out_ready = ready_r;

  tf_addr_seq_gen #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  tf_addr_seq_gen #(.LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.master));

  logic  obs_valid, obs_busy, obs_done;
  beat_t obs_b;

  always_comb begin
    if (sel) begin
      obs_valid   = if4.out_valid;
      obs_busy    = if4.busy;
      obs_done    = if4.done;
      obs_b.addr  = if4.tf_addr;
      obs_b.en    = if4.lane_en;
      obs_b.stage = if4.stage;
      obs_b.last  = if4.last;
    end else begin
      obs_valid   = if1.out_valid;
      obs_busy    = if1.busy;
      obs_done    = if1.done;
      obs_b.addr  = {27'd0, if1.tf_addr};
      obs_b.en    = {3'd0, if1.lane_en};
      obs_b.stage = if1.stage;
      obs_b.last  = if1.last;
    end
  end

  // Reference: counts 2,8,32,128; inverse table sits 170 entries above the forward one.
  task automatic build_exp(input int lanes, input logic md);
    int s, c, b;
    beat_t e;
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      s = md ? 3 - n : n;
      c = 2 << (2 * s);
      b = 0;
      for (int j = 0; j < s; j++) b += 2 << (2 * j);
      for (int k = 0; k < c; k += lanes) begin
        e = '0;
        for (int i = 0; i < lanes; i++) begin
          if (k + i < c) begin
            e.en[i]         = 1'b1;
            e.addr[i*9 +: 9] = 9'((md ? 170 : 0) + b + k + i);
          end
        end
        e.stage = 2'(s);
        e.last  = (n == 3) && (k + lanes >= c);
        exp_q.push_back(e);
      end
    end
  endtask

  // Drives one run and checks every transferred beat, stall stability and the done pulse.
  task automatic run_seq(input logic use4, input logic md, input int stall_pct,
                         input int abort_at, input bit poke, input bit launched,
                         input bit check_pulse);
    int    idx, cyc;
    bit    hold;
    beat_t held;
    sel = use4;
    build_exp(use4 ? 4 : 1, md);
    if (!launched) begin
      @(negedge clk);
      start_r = 1'b1;
      mode_r  = md;
      @(negedge clk);
      start_r = 1'b0;
      mode_r  = 1'($urandom);
      n_tests++;
      if (obs_busy !== 1'b1 || obs_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL launch: busy=%b valid=%b, required 1 1", obs_busy, obs_valid);
      end
    end
    idx = 0; cyc = 0; hold = 0; held = '0;
    while (idx < exp_q.size() && cyc < 4000 && !(abort_at >= 0 && idx >= abort_at)) begin
      if (!obs_valid) begin
        n_tests++; n_fail++;
        $display("FAIL valid_drop: beat %0d valid=0, required 1", idx);
      end
      if (hold) begin
        n_tests++;
        if (obs_b !== held) begin
          n_fail++;
          $display("FAIL stall_hold: beat %0d got %h, required %h", idx, obs_b, held);
        end
      end
      ready_r = ($urandom_range(99) >= stall_pct);
      if (ready_r && obs_valid) begin
        n_tests++;
        if (obs_b !== exp_q[idx]) begin
          n_fail++;
          $display("FAIL beat: idx %0d got addr=%h en=%b stg=%0d last=%b, required addr=%h en=%b stg=%0d last=%b",
                   idx, obs_b.addr, obs_b.en, obs_b.stage, obs_b.last,
                   exp_q[idx].addr, exp_q[idx].en, exp_q[idx].stage, exp_q[idx].last);
        end
        idx++;
        hold = 0;
      end else begin
        hold = obs_valid;
        held = obs_b;
      end
      if (poke) begin
        start_r = 1'($urandom);
        mode_r  = 1'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    start_r = 1'b0;
    ready_r = 1'b1;
    if (abort_at >= 0 && idx >= abort_at) return;
    n_tests++;
    if (idx < exp_q.size()) begin
      n_fail++;
      $display("FAIL timeout: %0d beats seen, required %0d", idx, exp_q.size());
      return;
    end
    n_tests++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle: done=%b busy=%b valid=%b, required 1 0 0", obs_done, obs_busy, obs_valid);
    end
    if (check_pulse) begin
      @(negedge clk);
      n_tests++;
      if (obs_done !== 1'b0 || obs_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse: done=%b valid=%b a cycle later, required 0 0", obs_done, obs_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      sel = 1'(u);
      #1;
      n_tests++;
      if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_b !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: dut%0d valid=%b busy=%b done=%b beat=%h, required all 0",
                 u, obs_valid, obs_busy, obs_done, obs_b);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ntt();
    run_seq(1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_intt();
    run_seq(1'b0, 1'b1, 0, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    run_seq(1'b0, 1'b0, 40, -1, 1'b0, 1'b0, 1'b1);
    run_seq(1'b0, 1'b1, 60, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_lanes4();
    run_seq(1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);
    run_seq(1'b1, 1'b1, 30, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_seq(1'b0, 1'b0, 25, -1, 1'b1, 1'b0, 1'b0);
    start_r = 1'b1;
    mode_r  = 1'b0;
    @(negedge clk);
    start_r = 1'b0;
    n_tests++;
    if (obs_done !== 1'b0 || obs_valid !== 1'b1 || obs_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_in_done: done=%b valid=%b busy=%b, required 0 1 1", obs_done, obs_valid, obs_busy);
    end
    run_seq(1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    run_seq(1'b0, 1'b0, 0, 50, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_b !== '0) begin
      n_fail++;
      $display("FAIL abort_async: valid=%b busy=%b done=%b beat=%h, required all 0",
               obs_valid, obs_busy, obs_done, obs_b);
    end
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (obs_done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: done=%b, required 0", obs_done);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs_done !== 1'b0 || obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: done=%b valid=%b, required 0 0", obs_done, obs_valid);
    end
    run_seq(1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_ntt();
    test_intt();
    test_stall();
    test_lanes4();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
